// File: rtl/multiplier_adder_subtractor_if.sv
// Operand/result bundle for the multiplier_adder_subtractor block.
interface multiplier_adder_subtractor_if #(
    parameter int unsigned WIDTH = 16
);
    // Capture enable and operands
    logic             en;
    logic [WIDTH-1:0] m1_in1;
    logic [WIDTH-1:0] m1_in2;
    logic [WIDTH-1:0] m2_in1;
    logic [WIDTH-1:0] m2_in2;
    logic [WIDTH-1:0] as_in1;
    logic [WIDTH-1:0] as_in2;
    logic             as_mode;

    // Combinational results
    logic [WIDTH-1:0] m1_out;
    logic [WIDTH-1:0] m2_out;
    logic [WIDTH-1:0] as_out;
    logic             as_ovf;

    // Registered results
    logic [WIDTH-1:0] m1_q;
    logic [WIDTH-1:0] m2_q;
    logic [WIDTH-1:0] as_q;
    logic             ovf_q;

    // Operand source side
    modport master (
        output en, m1_in1, m1_in2, m2_in1, m2_in2, as_in1, as_in2, as_mode,
        input  m1_out, m2_out, as_out, as_ovf, m1_q, m2_q, as_q, ovf_q
    );

    // Arithmetic block side
    modport slave (
        input  en, m1_in1, m1_in2, m2_in1, m2_in2, as_in1, as_in2, as_mode,
        output m1_out, m2_out, as_out, as_ovf, m1_q, m2_q, as_q, ovf_q
    );
endinterface

// File: rtl/multiplier_adder_subtractor.sv
// Two independent signed multipliers and a signed adder/subtractor, each with a
// combinational result and an enable-gated registered copy.
module multiplier_adder_subtractor #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    multiplier_adder_subtractor_if.slave  bus
);
    localparam int unsigned PW = 2 * WIDTH;

    // Sign-extend an operand to product width so an unsigned multiply yields
    // the correct two's-complement product in its low PW bits.
    function automatic logic [PW-1:0] sext(input logic [WIDTH-1:0] v);
        return {{WIDTH{v[WIDTH-1]}}, v};
    endfunction

    logic [WIDTH-1:0] m1_c;
    logic [WIDTH-1:0] m2_c;
    logic [WIDTH-1:0] as_c;
    logic             ovf_c;

    logic [WIDTH-1:0] m1_d;
    logic [WIDTH-1:0] m2_d;
    logic [WIDTH-1:0] as_d;
    logic             ovf_d;

    logic [WIDTH-1:0] m1_q;
    logic [WIDTH-1:0] m2_q;
    logic [WIDTH-1:0] as_q;
    logic             ovf_q;

    logic             a_sign;
    logic             b_sign;
    logic             r_sign;

    // Full-width products truncated to WIDTH; high bits dropped, no saturation
    always_comb begin
        m1_c = WIDTH'(sext(bus.m1_in1) * sext(bus.m1_in2));
        m2_c = WIDTH'(sext(bus.m2_in1) * sext(bus.m2_in2));
    end

    // Wrapping add/subtract with signed-overflow detection from the sign bits
    always_comb begin
        as_c   = '0;
        ovf_c  = 1'b0;
        a_sign = bus.as_in1[WIDTH-1];
        b_sign = bus.as_in2[WIDTH-1];
        if (bus.as_mode) begin
            as_c = bus.as_in1 - bus.as_in2;
        end else begin
            as_c = bus.as_in1 + bus.as_in2;
        end
        r_sign = as_c[WIDTH-1];
        if (bus.as_mode) begin
            ovf_c = (a_sign != b_sign) && (r_sign != a_sign);
        end else begin
            ovf_c = (a_sign == b_sign) && (r_sign != a_sign);
        end
    end

    // Next register values: load on enable, otherwise hold
    always_comb begin
        m1_d  = m1_q;
        m2_d  = m2_q;
        as_d  = as_q;
        ovf_d = ovf_q;
        if (bus.en) begin
            m1_d  = m1_c;
            m2_d  = m2_c;
            as_d  = as_c;
            ovf_d = ovf_c;
        end
    end

    // Result registers with asynchronous active-high clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m1_q  <= '0;
            m2_q  <= '0;
            as_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            m1_q  <= m1_d;
            m2_q  <= m2_d;
            as_q  <= as_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.m1_out = m1_c;
    assign bus.m2_out = m2_c;
    assign bus.as_out = as_c;
    assign bus.as_ovf = ovf_c;
    assign bus.m1_q   = m1_q;
    assign bus.m2_q   = m2_q;
    assign bus.as_q   = as_q;
    assign bus.ovf_q  = ovf_q;

endmodule

// File: tb/tb_multiplier_adder_subtractor.sv
// Directed bench for multiplier_adder_subtractor with hand-computed expectations.
module tb_multiplier_adder_subtractor;
    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    multiplier_adder_subtractor_if #(.WIDTH(16)) bus ();

    multiplier_adder_subtractor #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int a1, input int a2, input int b1, input int b2,
                           input int c1, input int c2, input logic mode);
        bus.m1_in1  = 16'(a1);
        bus.m1_in2  = 16'(a2);
        bus.m2_in1  = 16'(b1);
        bus.m2_in2  = 16'(b2);
        bus.as_in1  = 16'(c1);
        bus.as_in2  = 16'(c2);
        bus.as_mode = mode;
    endtask

    task automatic chk_q(input string tag, input logic [15:0] m1, input logic [15:0] m2,
                         input logic [15:0] as_v, input logic ovf);
        chk({tag, "_m1_q"}, 32'(bus.m1_q), 32'(m1));
        chk({tag, "_m2_q"}, 32'(bus.m2_q), 32'(m2));
        chk({tag, "_as_q"}, 32'(bus.as_q), 32'(as_v));
        chk({tag, "_ovf_q"}, 32'(bus.ovf_q), 32'(ovf));
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus.en   = 1'b0;
        set_ops(-2, 3, 7, -4, 5, 7, 1'b1);

        // Reset state, and combinational path unaffected by reset
        #3;
        chk_q("rst", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        chk("rst_m1_out", 32'(bus.m1_out), 32'h0000FFFA);
        chk("rst_as_out", 32'(bus.as_out), 32'h0000FFFE);

        @(negedge clk);
        reset = 1'b0;

        // Multiplier sign handling and add/sub basics
        #1;
        chk("sign_m1", 32'(bus.m1_out), 32'h0000FFFA);
        chk("sign_m2", 32'(bus.m2_out), 32'h0000FFE4);
        chk("sub_5_7", 32'(bus.as_out), 32'h0000FFFE);
        chk("sub_5_7_ovf", 32'(bus.as_ovf), 32'h0);
        set_ops(300, 300, -300, 300, 5, 7, 1'b0);
        #1;
        chk("trunc_m1", 32'(bus.m1_out), 32'h00005F90);
        chk("trunc_m2", 32'(bus.m2_out), 32'h0000A070);
        chk("add_5_7", 32'(bus.as_out), 32'h0000000C);
        chk("add_5_7_ovf", 32'(bus.as_ovf), 32'h0);

        // Overflow boundaries and extreme products
        set_ops(-32768, -1, 255, 255, 32767, 1, 1'b0);
        #1;
        chk("min_x_neg1", 32'(bus.m1_out), 32'h00008000);
        chk("m2_255sq", 32'(bus.m2_out), 32'h0000FE01);
        chk("add_ovf_out", 32'(bus.as_out), 32'h00008000);
        chk("add_ovf", 32'(bus.as_ovf), 32'h1);
        set_ops(0, 5, 1, 1, -32768, 1, 1'b1);
        #1;
        chk("m1_zero", 32'(bus.m1_out), 32'h0);
        chk("sub_ovf_out", 32'(bus.as_out), 32'h00007FFF);
        chk("sub_ovf", 32'(bus.as_ovf), 32'h1);
        set_ops(0, 0, 0, 0, -32768, -1, 1'b0);
        #1;
        chk("add_negneg_out", 32'(bus.as_out), 32'h00007FFF);
        chk("add_negneg_ovf", 32'(bus.as_ovf), 32'h1);
        set_ops(0, 0, 0, 0, 0, -32768, 1'b1);
        #1;
        chk("sub_0_min_out", 32'(bus.as_out), 32'h00008000);
        chk("sub_0_min_ovf", 32'(bus.as_ovf), 32'h1);
        set_ops(0, 0, 0, 0, -1, 1, 1'b0);
        #1;
        chk("add_cancel_out", 32'(bus.as_out), 32'h0);
        chk("add_cancel_ovf", 32'(bus.as_ovf), 32'h0);
        set_ops(0, 0, 0, 0, -5, -3, 1'b1);
        #1;
        chk("sub_samesign_out", 32'(bus.as_out), 32'h0000FFFE);
        chk("sub_samesign_ovf", 32'(bus.as_ovf), 32'h0);

        // Edges with en=0 so far must not have captured anything
        chk_q("no_en", 16'h0000, 16'h0000, 16'h0000, 1'b0);

        // First capture after reset release
        @(negedge clk);
        set_ops(-2, 3, 7, -4, 5, 7, 1'b1);
        bus.en = 1'b1;
        #1;
        chk_q("pre_edge", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        @(posedge clk);
        #1;
        chk_q("cap1", 16'hFFFA, 16'hFFE4, 16'hFFFE, 1'b0);

        // Hold across three edges with en=0 while inputs change
        @(negedge clk);
        bus.en = 1'b0;
        set_ops(300, 300, -32768, -1, 32767, 1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_q("hold", 16'hFFFA, 16'hFFE4, 16'hFFFE, 1'b0);
        end

        // Re-enable and capture the changed inputs
        @(negedge clk);
        bus.en = 1'b1;
        @(posedge clk);
        #1;
        chk_q("cap2", 16'h5F90, 16'h8000, 16'h8000, 1'b1);

        // Reset between edges with en=1: clears registers at once, not the comb path
        #2;
        reset = 1'b1;
        #1;
        chk_q("mid_rst", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        chk("mid_rst_m1_out", 32'(bus.m1_out), 32'h00005F90);
        chk("mid_rst_as_ovf", 32'(bus.as_ovf), 32'h1);
        @(posedge clk);
        #1;
        chk_q("rst_edge", 16'h0000, 16'h0000, 16'h0000, 1'b0);

        // Release reset; next enabled edge captures normally
        @(negedge clk);
        reset = 1'b0;
        set_ops(-2, 3, 7, -4, 5, 7, 1'b1);
        @(posedge clk);
        #1;
        chk_q("post_rst", 16'hFFFA, 16'hFFE4, 16'hFFFE, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/multiplier_adder_subtractor.md
MULTIPLIER_ADDER_SUBTRACTOR -- requirements
Module: multiplier_adder_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and result width in bits (legal range 4..32).
REQ-002 The block SHALL have port clk, input, 1 bit: rising-edge clock for the output registers.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port en, input, 1 bit: capture enable for the registered outputs.
REQ-005 The block SHALL have ports m1_in1 and m1_in2, input, WIDTH bits each: signed operands of multiplier 1.
REQ-006 The block SHALL have ports m2_in1 and m2_in2, input, WIDTH bits each: signed operands of multiplier 2.
REQ-007 The block SHALL have ports as_in1 and as_in2, input, WIDTH bits each: signed operands of the adder/subtractor.
REQ-008 The block SHALL have port as_mode, input, 1 bit: 0 selects add, 1 selects subtract.
REQ-009 The block SHALL have ports m1_out, m2_out and as_out, output, WIDTH bits each: combinational results.
REQ-010 The block SHALL have port as_ovf, output, 1 bit: combinational signed-overflow flag of the adder/subtractor.
REQ-011 The block SHALL have ports m1_q, m2_q and as_q, output, WIDTH bits each: registered copies of m1_out, m2_out and as_out.
REQ-012 The block SHALL have port ovf_q, output, 1 bit: registered copy of as_ovf.

Function
REQ-013 m1_out SHALL equal the low WIDTH bits of the full two's-complement product m1_in1 * m1_in2, computed with no clock latency.
REQ-014 m2_out SHALL follow the same rule as REQ-013 for m2_in1 and m2_in2, independently of multiplier 1.
REQ-015 Multiplier products SHALL be computed at 2*WIDTH bits internally and then truncated; high bits are discarded with no saturation.
REQ-016 With as_mode=0, as_out SHALL equal as_in1 + as_in2 modulo 2^WIDTH.
REQ-017 With as_mode=1, as_out SHALL equal as_in1 - as_in2 (in1 minus in2) modulo 2^WIDTH.
REQ-018 as_out SHALL wrap on overflow with no saturation.
REQ-019 In add mode, as_ovf SHALL be 1 exactly when both operands have the same sign and the result sign differs from it.
REQ-020 In subtract mode, as_ovf SHALL be 1 exactly when the operand signs differ and the result sign differs from the sign of as_in1.
REQ-021 All three units SHALL operate concurrently and SHALL share no state.
REQ-022 Combinational outputs SHALL depend only on the current inputs, with no dependence on clk, en or reset.
REQ-023 On a rising clk edge with en=1 and reset=0, m1_q, m2_q, as_q and ovf_q SHALL load m1_out, m2_out, as_out and as_ovf.
REQ-024 On a rising clk edge with en=0, the registered outputs SHALL hold their values.
REQ-025 Registered outputs SHALL have a latency of exactly 1 clock from the inputs sampled at the capturing edge.
REQ-026 Inputs changing in the same cycle as a capture SHALL be sampled at their pre-edge values.
REQ-027 Operands SHALL be treated as signed in all cases; there is no unsigned mode.

Reset
REQ-028 While reset=1, m1_q, m2_q, as_q and ovf_q SHALL be 0, independent of clk and en.
REQ-029 Reset SHALL take effect immediately on assertion, including mid-operation with en=1.
REQ-030 Reset SHALL have no effect on the combinational outputs m1_out, m2_out, as_out and as_ovf.
REQ-031 After reset deasserts, the first rising edge with en=1 SHALL capture normally.

Verification
REQ-032 Multiplier sign: m1_in1=-2, m1_in2=3 -> m1_out=16'hFFFA (-6); m2_in1=7, m2_in2=-4 -> m2_out=16'hFFE4 (-28).
REQ-033 Multiplier truncation: m1_in1=300, m1_in2=300 -> m1_out=24464 (16'h5F90).
REQ-034 Add/sub: as_in1=5, as_in2=7, as_mode=1 -> as_out=-2 and as_ovf=0; same operands with as_mode=0 -> as_out=12.
REQ-035 Overflow: 32767+1 in add mode -> as_out=16'h8000 and as_ovf=1; -32768-1 in subtract mode -> as_out=16'h7FFF and as_ovf=1.
REQ-036 Register/enable: apply operands with en=1 -> *_q valid after 1 edge; set en=0, change inputs -> *_q unchanged across 3 edges.
REQ-037 Reset mid-operation: assert reset between edges with en=1 -> all *_q=0 immediately while m1_out stays correct; deassert reset -> next edge captures.
